// File: rtl/change_dispenser.sv
// Change dispenser: pays credit minus PRICE as 25/10/5 coins through per-coin
// req/ack hopper handshakes, with a sticky fault on unpayable change or hopper timeout.
module change_dispenser #(
    parameter int unsigned PRICE   = 50,
    parameter int unsigned AMT_W   = 7,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] credit,
    input  logic             clear_fault,
    input  logic             empty_25,
    input  logic             empty_10,
    input  logic             empty_5,
    input  logic             eject_ack,
    output logic             eject_25,
    output logic             eject_10,
    output logic             eject_5,
    output logic [AMT_W-1:0] owed,
    output logic             busy,
    output logic             done,
    output logic             fault
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EJECT,
        GAP,
        DONE,
        FAULT
    } state_t;

    typedef enum logic [1:0] {
        COIN_25,
        COIN_10,
        COIN_5
    } coin_t;

    state_t           state;
    state_t           state_nx;
    coin_t            coin;
    coin_t            coin_nx;
    logic [AMT_W-1:0] owed_nx;
    logic [CNT_W-1:0] tcnt;
    logic [CNT_W-1:0] tcnt_nx;
    logic [AMT_W-1:0] coin_val_c;

    // Face value of the latched denomination
    always_comb begin
        coin_val_c = AMT_W'(5);
        case (coin)
            COIN_25: coin_val_c = AMT_W'(25);
            COIN_10: coin_val_c = AMT_W'(10);
            default: coin_val_c = AMT_W'(5);
        endcase
    end

    // Next-state, denomination selection, owed and timeout bookkeeping
    always_comb begin
        state_nx = state;
        coin_nx  = coin;
        owed_nx  = owed;
        tcnt_nx  = tcnt;
        case (state)
            IDLE: begin
                if (start) begin
                    owed_nx  = (credit >= AMT_W'(PRICE)) ? credit - AMT_W'(PRICE) : '0;
                    state_nx = SELECT;
                end
            end
            SELECT: begin
                tcnt_nx = '0;
                if (owed == '0) begin
                    state_nx = DONE;
                end else if (owed >= AMT_W'(25) && !empty_25) begin
                    coin_nx  = COIN_25;
                    state_nx = EJECT;
                end else if (owed >= AMT_W'(10) && !empty_10) begin
                    coin_nx  = COIN_10;
                    state_nx = EJECT;
                end else if (owed >= AMT_W'(5) && !empty_5) begin
                    coin_nx  = COIN_5;
                    state_nx = EJECT;
                end else begin
                    state_nx = FAULT;
                end
            end
            EJECT: begin
                if (eject_ack) begin
                    owed_nx  = owed - coin_val_c;
                    state_nx = GAP;
                end else if (tcnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nx = FAULT;
                end else begin
                    tcnt_nx = tcnt + CNT_W'(1);
                end
            end
            GAP:  state_nx = SELECT;
            DONE: state_nx = IDLE;
            FAULT: begin
                if (clear_fault) begin
                    owed_nx  = '0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register; outputs are decoded from the next state so they are flopped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            coin     <= COIN_25;
            owed     <= '0;
            tcnt     <= '0;
            eject_25 <= 1'b0;
            eject_10 <= 1'b0;
            eject_5  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nx;
            coin     <= coin_nx;
            owed     <= owed_nx;
            tcnt     <= tcnt_nx;
            eject_25 <= (state_nx == EJECT) && (coin_nx == COIN_25);
            eject_10 <= (state_nx == EJECT) && (coin_nx == COIN_10);
            eject_5  <= (state_nx == EJECT) && (coin_nx == COIN_5);
            busy     <= (state_nx == SELECT) || (state_nx == EJECT) ||
                        (state_nx == GAP) || (state_nx == DONE);
            done     <= (state_nx == DONE);
            fault    <= (state_nx == FAULT);
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus randomized
// payouts checked against a greedy coin-change reference model.
module tb_change_dispenser;

    localparam int unsigned PRICE   = 50;
    localparam int unsigned AMT_W   = 7;
    localparam int unsigned TIMEOUT = 12;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [AMT_W-1:0] credit;
    logic             clear_fault;
    logic             empty_25;
    logic             empty_10;
    logic             empty_5;
    logic             eject_ack;
    logic             eject_25;
    logic             eject_10;
    logic             eject_5;
    logic [AMT_W-1:0] owed;
    logic             busy;
    logic             done;
    logic             fault;

    int vectors = 0;
    int errors  = 0;

    int exp_q[$];
    int exp_start;
    int exp_rem;
    bit exp_flt;

    change_dispenser #(.PRICE(PRICE), .AMT_W(AMT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .credit(credit),
        .clear_fault(clear_fault), .empty_25(empty_25), .empty_10(empty_10),
        .empty_5(empty_5), .eject_ack(eject_ack), .eject_25(eject_25),
        .eject_10(eject_10), .eject_5(eject_5), .owed(owed), .busy(busy),
        .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    // Reference: greedy change from the largest available coin not exceeding the remainder
    task automatic build_model(input int cr, input bit e25, input bit e10, input bit e5);
        int rem;
        rem = (cr >= int'(PRICE)) ? cr - int'(PRICE) : 0;
        exp_start = rem;
        exp_q.delete();
        exp_flt = 1'b0;
        while (rem > 0 && !exp_flt) begin
            if (rem >= 25 && !e25) begin
                exp_q.push_back(25); rem -= 25;
            end else if (rem >= 10 && !e10) begin
                exp_q.push_back(10); rem -= 10;
            end else if (rem >= 5 && !e5) begin
                exp_q.push_back(5); rem -= 5;
            end else begin
                exp_flt = 1'b1;
            end
        end
        exp_rem = rem;
    endtask

    // ack_delay == 0 means the hopper never acknowledges
    task automatic run_payout(input int cr, input int ack_delay, input bit poke, input string name);
        int cyc, high_len, low_len, coin_idx, done_cnt, done_cyc, cur_d, run_owed;
        int want_coins, want_owed, want_d;
        bit want_flt, finished;
        logic [2:0] ej, prev_ej;
        build_model(cr, empty_25, empty_10, empty_5);
        if (ack_delay == 0) begin
            want_coins = (exp_q.size() > 0) ? 1 : 0;
            want_flt   = (exp_q.size() > 0) || exp_flt;
            want_owed  = (exp_q.size() > 0) ? exp_start : exp_rem;
        end else begin
            want_coins = exp_q.size();
            want_flt   = exp_flt;
            want_owed  = exp_rem;
        end
        run_owed = exp_start;
        high_len = 0; low_len = 0; coin_idx = 0; done_cnt = 0; done_cyc = 0;
        cur_d = 0; finished = 1'b0; prev_ej = 3'b000;

        @(negedge clk);
        start = 1'b1; credit = AMT_W'(cr); eject_ack = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        vectors++;
        if (busy !== 1'b1 || owed !== AMT_W'(exp_start)) begin
            errors++;
            $display("FAIL %s load: busy=%b owed=%0d, expected busy=1 owed=%0d", name, busy, owed, exp_start);
        end

        while (!finished && cyc < 400) begin
            ej = {eject_25, eject_10, eject_5};
            vectors++;
            if ($countones(ej) > 1) begin
                errors++;
                $display("FAIL %s onehot: eject={25:%b,10:%b,5:%b}, expected at most one", name, ej[2], ej[1], ej[0]);
            end
            if (prev_ej == 3'b000 && ej != 3'b000) begin
                cur_d  = ej[2] ? 25 : (ej[1] ? 10 : 5);
                want_d = (coin_idx < exp_q.size()) ? exp_q[coin_idx] : 0;
                vectors++;
                if (cur_d != want_d) begin
                    errors++;
                    $display("FAIL %s coin%0d: ejected %0d, expected %0d", name, coin_idx, cur_d, want_d);
                end
                vectors++;
                if (coin_idx == 0 && cyc != 2) begin
                    errors++;
                    $display("FAIL %s first_eject: at cycle %0d, expected cycle 2", name, cyc);
                end else if (coin_idx != 0 && low_len != 2) begin
                    errors++;
                    $display("FAIL %s gap: %0d low cycles, expected 2", name, low_len);
                end
                high_len = 1;
            end else if (ej != 3'b000) begin
                high_len++;
            end
            if (prev_ej != 3'b000 && ej == 3'b000) begin
                if (ack_delay != 0) begin
                    run_owed -= cur_d;
                    vectors++;
                    if (high_len != ack_delay || owed !== AMT_W'(run_owed)) begin
                        errors++;
                        $display("FAIL %s paid: high=%0d owed=%0d, expected high=%0d owed=%0d", name, high_len, owed, ack_delay, run_owed);
                    end
                end else begin
                    vectors++;
                    if (high_len != int'(TIMEOUT) || fault !== 1'b1 || owed !== AMT_W'(run_owed)) begin
                        errors++;
                        $display("FAIL %s timeout: high=%0d fault=%b owed=%0d, expected high=%0d fault=1 owed=%0d",
                                 name, high_len, fault, owed, TIMEOUT, run_owed);
                    end
                end
                coin_idx++;
                low_len = 0;
            end
            if (ej == 3'b000) low_len++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (fault === 1'b1) finished = 1'b1;
            if (done_cnt > 0 && done === 1'b0 && busy === 1'b0) finished = 1'b1;
            eject_ack = (ack_delay != 0) && (ej != 3'b000) && (high_len == ack_delay);
            start     = poke && (ej != 3'b000) && (high_len == 1) && (coin_idx == 0);
            if (start) credit = AMT_W'(120);
            prev_ej = ej;
            @(negedge clk);
            cyc++;
        end
        eject_ack = 1'b0;
        start = 1'b0;

        vectors++;
        if (!finished) begin
            errors++;
            $display("FAIL %s finish: no done/fault within %0d cycles", name, cyc);
        end
        vectors++;
        if (coin_idx != want_coins || fault !== want_flt || owed !== AMT_W'(want_owed)) begin
            errors++;
            $display("FAIL %s result: coins=%0d fault=%b owed=%0d, expected coins=%0d fault=%b owed=%0d",
                     name, coin_idx, fault, owed, want_coins, want_flt, want_owed);
        end
        vectors++;
        if (done_cnt != (want_flt ? 0 : 1)) begin
            errors++;
            $display("FAIL %s done_count: %0d pulses, expected %0d", name, done_cnt, want_flt ? 0 : 1);
        end
        if (!want_flt && want_coins == 0) begin
            vectors++;
            if (done_cyc != 2) begin
                errors++;
                $display("FAIL %s done_latency: done at cycle %0d, expected cycle 2", name, done_cyc);
            end
        end
    endtask

    task automatic do_clear(input string name);
        @(negedge clk);
        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
        vectors++;
        if (fault !== 1'b0 || owed !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s clear: fault=%b owed=%0d busy=%b, expected 0/0/0", name, fault, owed, busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; credit = '0; clear_fault = 1'b0;
        empty_25 = 1'b0; empty_10 = 1'b0; empty_5 = 1'b0; eject_ack = 1'b0;
        #12;
        vectors++;
        if ({eject_25, eject_10, eject_5, busy, done, fault} !== 6'b0 || owed !== '0) begin
            errors++;
            $display("FAIL reset: ejects=%b%b%b busy=%b done=%b fault=%b owed=%0d, expected all 0",
                     eject_25, eject_10, eject_5, busy, done, fault, owed);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || owed !== '0) begin
            errors++;
            $display("FAIL reset_release: busy=%b owed=%0d, expected 0/0", busy, owed);
        end
    endtask

    task automatic test_basic;
        run_payout(90, 2, 1'b0, "basic90");
    endtask

    task automatic test_zero_change;
        run_payout(50, 2, 1'b0, "zero50");
        run_payout(30, 2, 1'b0, "zero30");
    endtask

    task automatic test_empty_hopper;
        empty_25 = 1'b1;
        run_payout(125, 1, 1'b0, "empty25");
        empty_25 = 1'b0;
    endtask

    task automatic test_fault_remainder;
        run_payout(93, 1, 1'b0, "remainder93");
        do_clear("remainder93");
        run_payout(85, 1, 1'b0, "after_clear");
    endtask

    task automatic test_timeout;
        run_payout(75, 0, 1'b1, "timeout75");
        do_clear("timeout75");
    endtask

    task automatic test_reset_mid;
        int waited;
        empty_25 = 1'b1;
        @(negedge clk);
        start = 1'b1; credit = AMT_W'(100);
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (eject_10 !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (eject_10 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid wait: eject_10=%b, expected 1 within 10 cycles", eject_10);
        end
        #1 reset = 1'b1;
        #1;
        vectors++;
        if (eject_10 !== 1'b0 || owed !== '0 || busy !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: eject_10=%b owed=%0d busy=%b fault=%b, expected all 0", eject_10, owed, busy, fault);
        end
        @(negedge clk);
        reset = 1'b0;
        eject_ack = 1'b1;
        @(negedge clk);
        eject_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if ({eject_25, eject_10, eject_5} !== 3'b000 || busy !== 1'b0 || owed !== '0) begin
            errors++;
            $display("FAIL idle_ack: ejects=%b%b%b busy=%b owed=%0d, expected idle",
                     eject_25, eject_10, eject_5, busy, owed);
        end
        empty_25 = 1'b0;
    endtask

    task automatic test_random;
        int cr, dly;
        for (int i = 0; i < 20; i++) begin
            cr  = int'($urandom_range(0, 127));
            dly = int'($urandom_range(1, 3));
            empty_25 = ($urandom_range(0, 3) == 0);
            empty_10 = ($urandom_range(0, 3) == 0);
            empty_5  = ($urandom_range(0, 3) == 0);
            run_payout(cr, dly, 1'b0, "random");
            if (fault === 1'b1) do_clear("random");
        end
        empty_25 = 1'b0; empty_10 = 1'b0; empty_5 = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero_change;
        test_empty_hopper;
        test_fault_remainder;
        test_timeout;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
